// File: rtl/mid_die_sq_sequencer.sv
// Operand-side sequencer for the mid-die squarer: launches an operand, waits the mode latency, captures, iterates.
// Build option MID_DIE_SEQ_TOPCHECK_EN enables the sticky err flag; without it err is tied low.
module mid_die_sq_sequencer #(
  parameter int NUM_ELEMENTS  = 21,
  parameter int BIT_LEN       = 51,
  parameter int ITER_W        = 32,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 bypass_cfg,
  input  logic [ITER_W-1:0]                    iterations,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_in,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_mid,
  output logic                                 bypass,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] low_grid_sum,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_out,
  output logic [ITER_W-1:0]                    iter_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int WAIT_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [WAIT_W-1:0] WAIT_ONE      = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD_BYP = WAIT_W'(SETTLE_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD_REG = WAIT_W'(SETTLE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  logic [1:0]                          state_r;
  logic [1:0]                          state_s;
  logic [WAIT_W-1:0]                   wait_cnt_r;
  logic [WAIT_W-1:0]                   wait_load_s;
  logic [ITER_W-1:0]                   remaining_r;
  logic [ITER_W-1:0]                   iter_count_r;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_mid_r;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_out_r;
  logic                                bypass_r;
  logic                                busy_r;
  logic                                done_r;

  assign wait_load_s = bypass_r ? WAIT_LOAD_BYP : WAIT_LOAD_REG;

  // Next-state selection; abort overrides every transition.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (iterations != '0)) state_s = ST_LAUNCH;
          else                             state_s = ST_IDLE;
        end
        ST_LAUNCH: begin
          if (wait_load_s != '0) state_s = ST_WAIT;
          else                   state_s = ST_CAPTURE;
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_ONE) state_s = ST_CAPTURE;
          else                        state_s = ST_WAIT;
        end
        ST_CAPTURE: begin
          if (remaining_r == ITER_W'(1)) state_s = ST_IDLE;
          else                           state_s = ST_LAUNCH;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, operand/result registers and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= '0;
      remaining_r  <= '0;
      iter_count_r <= '0;
      sq_mid_r     <= '0;
      sq_out_r     <= '0;
      bypass_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= 1'b0;
      if (!abort) begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              bypass_r     <= bypass_cfg;
              sq_mid_r     <= sq_in;
              remaining_r  <= iterations;
              iter_count_r <= '0;
              if (iterations == '0) done_r <= 1'b1;
            end
          end
          ST_LAUNCH:  wait_cnt_r <= wait_load_s;
          ST_WAIT:    wait_cnt_r <= wait_cnt_r - WAIT_ONE;
          ST_CAPTURE: begin
            sq_out_r    <= low_grid_sum;
            sq_mid_r    <= low_grid_sum;
            remaining_r <= remaining_r - ITER_W'(1);
            if (iter_count_r != '1) iter_count_r <= iter_count_r + ITER_W'(1);
            if (remaining_r == ITER_W'(1)) done_r <= 1'b1;
          end
          default: wait_cnt_r <= '0;
        endcase
      end
    end
  end

  assign sq_mid     = sq_mid_r;
  assign sq_out     = sq_out_r;
  assign bypass     = bypass_r;
  assign iter_count = iter_count_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef MID_DIE_SEQ_TOPCHECK_EN
  logic err_r;

  // Sticky flag: nonzero guaranteed-zero top bits at a capture, or start while a run is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_CAPTURE && !abort &&
                  (|low_grid_sum[NUM_ELEMENTS-1][BIT_LEN-1:21])) ||
                 (start && state_r != ST_IDLE)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mid_die_sq_sequencer.sv
// Self-checking bench: a behavioural mid-die model adds a per-run constant to every word;
// expected results come from run-level arithmetic (base + captures*k, done at 1 + N*(2+W)).
module tb_mid_die_sq_sequencer;

  localparam int NE = 21;
  localparam int BL = 51;
  localparam int IW = 32;
`ifdef MID_DIE_SEQ_TOPCHECK_EN
  localparam bit TOPCHK = 1'b1;
`else
  localparam bit TOPCHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   bypass_cfg = 1'b0;
  logic [IW-1:0]          iterations = '0;
  logic [NE-1:0][BL-1:0]  sq_in = '0;
  logic [NE-1:0][BL-1:0]  sq_mid;
  logic                   bypass;
  logic [NE-1:0][BL-1:0]  low_grid_sum;
  logic [NE-1:0][BL-1:0]  sq_out;
  logic [IW-1:0]          iter_count;
  logic                   busy;
  logic                   done;
  logic                   err;

  mid_die_sq_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bypass_cfg(bypass_cfg), .iterations(iterations), .sq_in(sq_in),
    .sq_mid(sq_mid), .bypass(bypass), .low_grid_sum(low_grid_sum),
    .sq_out(sq_out), .iter_count(iter_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Mid-die model: result = operand + k per word; combinational in bypass, one register otherwise.
  logic [BL-1:0]         k_cur = '0;
  logic [NE-1:0][BL-1:0] f_s;
  logic [NE-1:0][BL-1:0] reg_q = '0;
  always_comb begin
    f_s = '0;
    for (int w = 0; w < NE; w++) f_s[w] = sq_mid[w] + k_cur;
  end
  always_ff @(posedge clk) reg_q <= f_s;
  assign low_grid_sum = bypass ? f_s : reg_q;

  int checks = 0;
  int errors = 0;
  logic [NE-1:0][BL-1:0] exp_out = '0;
  logic [IW-1:0]         exp_iter = '0;
  logic                  exp_err = 1'b0;
  logic                  exp_byp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic [NE-1:0][BL-1:0] got,
                             input logic [NE-1:0][BL-1:0] exp);
    for (int w = 0; w < NE; w++) check($sformatf("%s[%0d]", tag, w), 64'(got[w]), 64'(exp[w]));
  endtask

  function automatic logic [BL-1:0] rnd51();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[BL-1:0];
  endfunction

  // True when any of the first n results of a word would carry bits above bit 20.
  function automatic bit top_hit(input logic [BL-1:0] b, input logic [BL-1:0] k, input int n);
    logic [BL-1:0] v;
    bit hit;
    v = b;
    hit = 1'b0;
    for (int i = 1; i <= n; i++) begin
      v = v + k;
      if (v[BL-1:21] != '0) hit = 1'b1;
    end
    return hit;
  endfunction

  // kmode: 0 identity, 1 plus one, 2 small k, 3 full-width random. abort_at: cycle index after T, 0 = none.
  task automatic do_run(input logic byp, input int n, input int kmode, input bit poke, input int abort_at);
    logic [NE-1:0][BL-1:0] base;
    int per, d, caps, poke_at, done_cnt, done_at, busy_err, exp_done_cnt, exp_done_at;
    for (int w = 0; w < NE; w++) base[w] = (kmode < 3) ? BL'($urandom_range(0, 20'hFFFFF)) : rnd51();
    case (kmode)
      0:       k_cur = '0;
      1:       k_cur = BL'(1);
      2:       k_cur = BL'($urandom_range(1, 1023));
      default: k_cur = rnd51();
    endcase
    per  = 2 + (byp ? 0 : 1);
    d    = 1 + n * per;
    caps = (abort_at > 0) ? (abort_at - 1) / per : n;
    if (caps > n) caps = n;
    poke_at = (poke && n > 0) ? $urandom_range(d - 1, 1) : 0;
    @(negedge clk);
    start = 1'b1; bypass_cfg = byp; iterations = IW'(n); sq_in = base;
    if (caps > 0) begin
      for (int w = 0; w < NE; w++) exp_out[w] = base[w] + BL'(caps) * k_cur;
      if (TOPCHK && top_hit(base[NE-1], k_cur, caps)) exp_err = 1'b1;
    end
    exp_iter = IW'(caps);
    exp_byp  = byp;
    exp_done_cnt = (abort_at > 0) ? 0 : 1;
    exp_done_at  = (abort_at > 0) ? 0 : d;
    done_cnt = 0; done_at = 0; busy_err = 0;
    for (int j = 1; j <= d + 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (j == abort_at);
      if (j == 1) begin
        check_words("sq_mid_launch", sq_mid, base);
        check("bypass_launch", 64'(bypass), 64'(byp));
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = j;
      end
      if (busy !== ((n > 0) && (j < d) && (abort_at == 0 || j <= abort_at))) busy_err++;
      if (j == poke_at) begin
        start = 1'b1; bypass_cfg = ~byp; iterations = IW'($urandom_range(1, 9)); sq_in[0] = rnd51();
        if (TOPCHK) exp_err = 1'b1;
      end
    end
    abort = 1'b0;
    check("done_count", 64'(done_cnt), 64'(exp_done_cnt));
    check("done_cycle", 64'(done_at), 64'(exp_done_at));
    check("busy_profile_errs", 64'(busy_err), 64'(0));
    check("iter_count", 64'(iter_count), 64'(exp_iter));
    check("bypass_hold", 64'(bypass), 64'(exp_byp));
    check("err", 64'(err), 64'(exp_err));
    check_words("sq_out", sq_out, exp_out);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_bypass", 64'(bypass), 64'(0));
    check("rst_iter", 64'(iter_count), 64'(0));
    check("rst_sq_mid_zero", 64'(sq_mid == '0), 64'(1));
    check("rst_sq_out_zero", 64'(sq_out == '0), 64'(1));
    rst_n = 1'b1;

    do_run(1'b1, 3, 0, 1'b0, 0);   // bypass identity: done at T+7
    do_run(1'b0, 4, 1, 1'b0, 0);   // registered +1: done at T+13
    do_run(1'b0, 0, 2, 1'b0, 0);   // zero iterations: done at T+1, sq_out unchanged
    do_run(1'b0, 5, 2, 1'b0, 7);   // abort right after the second capture
    do_run(1'b1, 4, 2, 1'b0, 4);   // abort in the second CAPTURE cycle blocks that capture

    // start and abort together in IDLE: start is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; iterations = IW'(3); bypass_cfg = ~exp_byp;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 64'(busy), 64'(0));
      check("start_abort_done", 64'(done), 64'(0));
    end
    check("start_abort_iter", 64'(iter_count), 64'(exp_iter));
    check("start_abort_bypass", 64'(bypass), 64'(exp_byp));

    for (int r = 0; r < 6; r++) do_run(1'($urandom_range(0, 1)), $urandom_range(1, 6), 3, 1'b1, 0);

    // reset during WAIT of a 5-iteration registered run
    @(negedge clk);
    start = 1'b1; bypass_cfg = 1'b0; iterations = IW'(5); sq_in[0] = rnd51();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_iter", 64'(iter_count), 64'(0));
    check("midrst_err", 64'(err), 64'(0));
    check("midrst_bypass", 64'(bypass), 64'(0));
    check("midrst_sq_mid_zero", 64'(sq_mid == '0), 64'(1));
    check("midrst_sq_out_zero", 64'(sq_out == '0), 64'(1));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("midrst_done", 64'(done), 64'(0));
    end
    rst_n = 1'b1;
    exp_out = '0; exp_iter = '0; exp_err = 1'b0; exp_byp = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("postrst_done", 64'(done), 64'(0));
    end
    do_run(1'b0, 2, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
